// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout game sequencer.
// The state encoding is visible on the GameState output.
package breakout_pkg;

   typedef enum logic [2:0] {
      ATTRACT = 3'd0,
      SERVE   = 3'd1,
      PLAY    = 3'd2,
      LOST    = 3'd3,
      CLEAR   = 3'd4,
      OVER    = 3'd5
   } game_state_t;

   localparam int         BRICKS_PER_WALL = 133;
   localparam logic [1:0] BALL_SPEED_SLOW = 2'd2;
   localparam logic [1:0] BALL_SPEED_FAST = 2'd3;

   // Maps a ball speed code onto the one-bit SpeedSel output.
   function automatic logic speed_sel(input logic [1:0] code);
      return (code == BALL_SPEED_FAST);
   endfunction

   // Adds one to a four-digit BCD value; the carry ripples through every digit.
   function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
               carry       = 1'b1;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end else begin
            carry = 1'b0;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/breakout_game_ctrl_bcd_score_counter.sv
// Four-digit BCD score register: clears on request, saturates at 9999.
module bcd_score_counter
   import breakout_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        inc,
   output logic [15:0] score_o,
   output logic        sat_o
);

   logic [15:0] score_q;
   logic [15:0] score_d;

   assign sat_o   = (score_q == 16'h9999);
   assign score_o = score_q;

   // Next score: clear wins, otherwise increment unless already saturated.
   always_comb begin
      score_d = score_q;
      if (clear) begin
         score_d = 16'h0000;
      end else if (inc && !sat_o) begin
         score_d = bcd_inc4(score_q);
      end else begin
         score_d = score_q;
      end
   end

   // Score register.
   always_ff @(posedge clk) begin
      if (reset) begin
         score_q <= 16'h0000;
      end else begin
         score_q <= score_d;
      end
   end

endmodule

// File: rtl/breakout_game_ctrl.sv
// Frame-level game sequencer: state machine, frame/brick/lives counters,
// ball gating and pulses for re-serve and brick-wall restore.
module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int LIVES        = 3,
   parameter int SERVE_FRAMES = 90,
   parameter int LOST_FRAMES  = 60,
   parameter int BRICKS       = BRICKS_PER_WALL,
   parameter int SPEEDUP_HITS = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        FrameTick,
   input  logic        BrickHit,
   input  logic        BallOut,
   input  logic        Start,
   output logic        BallRun,
   output logic        BallServe,
   output logic        RestoreBrickwall,
   output logic        SpeedSel,
   output logic [1:0]  Lives,
   output logic [15:0] Score,
   output logic [2:0]  GameState
);

   localparam logic [1:0] LIVES_C   = 2'(LIVES);
   localparam logic [7:0] SERVE_C   = 8'(SERVE_FRAMES);
   localparam logic [7:0] LOST_C    = 8'(LOST_FRAMES);
   localparam logic [7:0] BRICKS_C  = 8'(BRICKS);
   localparam logic [7:0] SPEEDUP_C = 8'(SPEEDUP_HITS);

   game_state_t state_q;
   logic [7:0]  frame_q;
   logic [7:0]  brick_q;
   logic [1:0]  lives_q;
   logic        armed_q;
   logic        start_q;
   logic        run_q;
   logic        serve_q;
   logic        restore_q;
   logic        speed_q;

   logic [7:0]  frame_inc_s;
   logic [7:0]  brick_inc_s;
   logic        hit_s;
   logic        serve_done_s;
   logic        lost_done_s;
   logic        new_game_s;
   logic        score_inc_s;
   logic        score_sat_s;

   assign hit_s        = BrickHit && (state_q == PLAY);
   assign serve_done_s = FrameTick && (frame_inc_s == SERVE_C);
   assign lost_done_s  = FrameTick && (frame_inc_s == LOST_C);
   assign new_game_s   = (state_q == ATTRACT) && armed_q && Start;
   assign score_inc_s  = hit_s && !score_sat_s;

   // Saturating increments for the frame and brick counters.
   always_comb begin
      frame_inc_s = frame_q;
      brick_inc_s = brick_q;
      if (frame_q != 8'd255) begin
         frame_inc_s = frame_q + 8'd1;
      end else begin
         frame_inc_s = frame_q;
      end
      if (hit_s && (brick_q != BRICKS_C)) begin
         brick_inc_s = brick_q + 8'd1;
      end else begin
         brick_inc_s = brick_q;
      end
   end

   bcd_score_counter u_score (
      .clk     (clk),
      .reset   (reset),
      .clear   (new_game_s),
      .inc     (score_inc_s),
      .score_o (Score),
      .sat_o   (score_sat_s)
   );

   // Game state machine with its counters and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ATTRACT;
         frame_q   <= 8'd0;
         brick_q   <= 8'd0;
         lives_q   <= LIVES_C;
         armed_q   <= 1'b1;
         start_q   <= 1'b0;
         run_q     <= 1'b0;
         serve_q   <= 1'b0;
         restore_q <= 1'b0;
         speed_q   <= 1'b0;
      end else begin
         start_q   <= Start;
         serve_q   <= 1'b0;
         restore_q <= 1'b0;
         frame_q   <= FrameTick ? frame_inc_s : frame_q;
         brick_q   <= brick_inc_s;
         if (hit_s && (brick_inc_s == SPEEDUP_C)) begin
            speed_q <= speed_sel(BALL_SPEED_FAST);
         end
         case (state_q)
            ATTRACT: begin
               // A held button must be seen released on a frame before it can start a game.
               if (FrameTick && !Start) begin
                  armed_q <= 1'b1;
               end
               if (new_game_s) begin
                  state_q   <= SERVE;
                  frame_q   <= 8'd0;
                  brick_q   <= 8'd0;
                  lives_q   <= LIVES_C;
                  speed_q   <= speed_sel(BALL_SPEED_SLOW);
                  serve_q   <= 1'b1;
                  restore_q <= 1'b1;
               end
            end
            SERVE: begin
               if (serve_done_s) begin
                  state_q <= PLAY;
                  frame_q <= 8'd0;
                  run_q   <= 1'b1;
               end
            end
            PLAY: begin
               if (FrameTick) begin
                  if (brick_inc_s == BRICKS_C) begin
                     state_q <= CLEAR;
                     frame_q <= 8'd0;
                     run_q   <= 1'b0;
                  end else if (BallOut) begin
                     state_q <= LOST;
                     frame_q <= 8'd0;
                     run_q   <= 1'b0;
                     lives_q <= (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                  end
               end
            end
            LOST: begin
               if (lost_done_s) begin
                  frame_q <= 8'd0;
                  if (lives_q == 2'd0) begin
                     state_q <= OVER;
                  end else begin
                     state_q <= SERVE;
                     serve_q <= 1'b1;
                  end
               end
            end
            CLEAR: begin
               if (lost_done_s) begin
                  state_q   <= SERVE;
                  frame_q   <= 8'd0;
                  brick_q   <= 8'd0;
                  speed_q   <= speed_sel(BALL_SPEED_SLOW);
                  serve_q   <= 1'b1;
                  restore_q <= 1'b1;
               end
            end
            OVER: begin
               if (Start && !start_q) begin
                  state_q <= ATTRACT;
                  frame_q <= 8'd0;
                  armed_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ATTRACT;
               frame_q <= 8'd0;
               run_q   <= 1'b0;
            end
         endcase
      end
   end

   assign BallRun          = run_q;
   assign BallServe        = serve_q;
   assign RestoreBrickwall = restore_q;
   assign SpeedSel         = speed_q;
   assign Lives            = lives_q;
   assign GameState        = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Randomized bench for breakout_game_ctrl against a per-cycle behavioural game model.
module tb_breakout_game_ctrl;

   localparam int LIVES        = 3;
   localparam int SERVE_FRAMES = 90;
   localparam int LOST_FRAMES  = 60;
   localparam int BRICKS       = 133;
   localparam int SPEEDUP_HITS = 16;
   localparam int FRAME_LEN    = 4;

   localparam int M_ATTRACT = 0;
   localparam int M_SERVE   = 1;
   localparam int M_PLAY    = 2;
   localparam int M_LOST    = 3;
   localparam int M_CLEAR   = 4;
   localparam int M_OVER    = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic        FrameTick;
   logic        BrickHit;
   logic        BallOut;
   logic        Start;
   logic        BallRun;
   logic        BallServe;
   logic        RestoreBrickwall;
   logic        SpeedSel;
   logic [1:0]  Lives;
   logic [15:0] Score;
   logic [2:0]  GameState;

   always #5 clk = ~clk;

   breakout_game_ctrl #(
      .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .LOST_FRAMES(LOST_FRAMES),
      .BRICKS(BRICKS), .SPEEDUP_HITS(SPEEDUP_HITS)
   ) dut (
      .clk(clk), .reset(reset), .FrameTick(FrameTick), .BrickHit(BrickHit),
      .BallOut(BallOut), .Start(Start), .BallRun(BallRun), .BallServe(BallServe),
      .RestoreBrickwall(RestoreBrickwall), .SpeedSel(SpeedSel), .Lives(Lives),
      .Score(Score), .GameState(GameState)
   );

   int n_checks = 0;
   int n_fail   = 0;

   int m_state, m_frames, m_bricks, m_lives, m_score;
   bit m_speed, m_armed, m_prev_st, m_serve, m_restore, m_run;
   bit cmp_en, saw_restore;
   int score_at_loss;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   // Game rules applied once per clock edge from the inputs sampled at that edge.
   task automatic model_step();
      int nxt;
      if (reset) begin
         m_state = M_ATTRACT; m_frames = 0; m_bricks = 0; m_lives = LIVES; m_score = 0;
         m_speed = 1'b0; m_armed = 1'b1; m_prev_st = 1'b0;
         m_serve = 1'b0; m_restore = 1'b0; m_run = 1'b0;
         return;
      end
      m_serve = 1'b0;
      m_restore = 1'b0;
      if (BrickHit && m_state == M_PLAY) begin
         if (m_score < 9999) m_score++;
         if (m_bricks < BRICKS) begin
            m_bricks++;
            if (m_bricks == SPEEDUP_HITS) m_speed = 1'b1;
         end
      end
      nxt = m_state;
      case (m_state)
         M_ATTRACT: begin
            if (m_armed && Start) begin
               nxt = M_SERVE; m_score = 0; m_lives = LIVES; m_bricks = 0;
               m_speed = 1'b0; m_serve = 1'b1; m_restore = 1'b1;
            end else if (FrameTick && !Start) begin
               m_armed = 1'b1;
            end
         end
         M_SERVE: if (FrameTick && m_frames + 1 >= SERVE_FRAMES) nxt = M_PLAY;
         M_PLAY: begin
            if (FrameTick) begin
               if (m_bricks == BRICKS) nxt = M_CLEAR;
               else if (BallOut) begin
                  nxt = M_LOST;
                  if (m_lives > 0) m_lives--;
               end
            end
         end
         M_LOST: begin
            if (FrameTick && m_frames + 1 >= LOST_FRAMES) begin
               if (m_lives == 0) nxt = M_OVER;
               else begin nxt = M_SERVE; m_serve = 1'b1; end
            end
         end
         M_CLEAR: begin
            if (FrameTick && m_frames + 1 >= LOST_FRAMES) begin
               nxt = M_SERVE; m_serve = 1'b1; m_restore = 1'b1;
               m_bricks = 0; m_speed = 1'b0;
            end
         end
         default: begin
            if (Start && !m_prev_st) begin nxt = M_ATTRACT; m_armed = 1'b0; end
         end
      endcase
      if (nxt != m_state) m_frames = 0;
      else if (FrameTick) m_frames = (m_frames >= 255) ? 255 : m_frames + 1;
      m_state = nxt;
      m_run = (m_state == M_PLAY);
      m_prev_st = Start;
   endtask

   task automatic step();
      logic [24:0] got;
      logic [24:0] exp;
      @(posedge clk);
      model_step();
      #1;
      saw_restore = saw_restore | RestoreBrickwall;
      got = {GameState, BallRun, BallServe, RestoreBrickwall, SpeedSel, Lives, Score};
      exp = {3'(m_state), m_run, m_serve, m_restore, m_speed, 2'(m_lives), to_bcd(m_score)};
      if (cmp_en) chk_eq("cycle", 32'(got), 32'(exp));
   endtask

   task automatic frame(input bit bo, input int hit_pct);
      for (int c = 0; c < FRAME_LEN; c++) begin
         FrameTick = (c == FRAME_LEN - 1);
         BallOut   = bo;
         BrickHit  = (int'($urandom_range(99)) < hit_pct);
         step();
      end
      FrameTick = 1'b0; BallOut = 1'b0; BrickHit = 1'b0;
   endtask

   task automatic frames(input int n, input int hit_pct);
      for (int f = 0; f < n; f++) frame(1'b0, hit_pct);
   endtask

   task automatic hit_once();
      BrickHit = 1'b1; step();
      BrickHit = 1'b0; step();
   endtask

   initial begin
      reset = 1'b1; FrameTick = 1'b0; BrickHit = 1'b0; BallOut = 1'b0; Start = 1'b0;
      cmp_en = 1'b1; saw_restore = 1'b0;
      repeat (3) step();
      chk_eq("rst_state", 32'(GameState), 32'd0);
      chk_eq("rst_lives", 32'(Lives), 32'd3);
      chk_eq("rst_score", 32'(Score), 32'd0);
      chk_eq("rst_outs", 32'({BallRun, BallServe, RestoreBrickwall, SpeedSel}), 32'd0);
      reset = 1'b0; step();

      Start = 1'b1; step();
      chk_eq("start_state", 32'(GameState), 32'd1);
      chk_eq("start_pulses", 32'({RestoreBrickwall, BallServe}), 32'd3);
      step();
      chk_eq("pulse_width", 32'({RestoreBrickwall, BallServe}), 32'd0);
      step(); Start = 1'b0;
      frames(SERVE_FRAMES - 1, 20);
      chk_eq("serve_hold", 32'({GameState, BallRun}), 32'({3'd1, 1'b0}));
      frames(1, 20);
      chk_eq("play_entry", 32'({GameState, BallRun}), 32'({3'd2, 1'b1}));

      for (int i = 0; i < 16; i++) hit_once();
      chk_eq("score_16", 32'(Score), 32'h0016);
      chk_eq("speed_fast", 32'(SpeedSel), 32'd1);
      hit_once();
      chk_eq("score_17", 32'(Score), 32'h0017);

      for (int k = 0; k < 3; k++) begin
         frames(int'($urandom_range(5, 1)), 25);
         frame(1'b1, 25);
         score_at_loss = m_score;
         chk_eq("lost_state", 32'(GameState), 32'd3);
         chk_eq("lives_dec", 32'(Lives), 32'(2 - k));
         frames(LOST_FRAMES, 25);
         chk_eq("score_held", 32'(Score), 32'(to_bcd(score_at_loss)));
         if (k < 2) begin
            chk_eq("reserve", 32'(GameState), 32'd1);
            frames(SERVE_FRAMES, 25);
         end else begin
            chk_eq("over", 32'({GameState, BallRun}), 32'({3'd5, 1'b0}));
         end
      end

      frames(3, 25);
      chk_eq("over_wait", 32'(GameState), 32'd5);
      Start = 1'b1; step();
      chk_eq("over_exit", 32'(GameState), 32'd0);
      frames(5, 0);
      chk_eq("no_autostart", 32'(GameState), 32'd0);
      chk_eq("attract_score", 32'(Score), 32'(to_bcd(score_at_loss)));
      Start = 1'b0; frame(1'b0, 0);
      Start = 1'b1; step();
      chk_eq("restart", 32'({GameState, Lives, Score}), 32'({3'd1, 2'd3, 16'h0000}));
      Start = 1'b0;
      frames(SERVE_FRAMES, 0);
      chk_eq("play2", 32'(GameState), 32'd2);

      BrickHit = 1'b1;
      for (int i = 0; i < BRICKS - 1; i++) step();
      FrameTick = 1'b1; BallOut = 1'b1; step();
      BrickHit = 1'b0; FrameTick = 1'b0; BallOut = 1'b0;
      chk_eq("clear_state", 32'(GameState), 32'd4);
      chk_eq("clear_lives", 32'(Lives), 32'd3);
      chk_eq("clear_score", 32'(Score), 32'h0133);
      saw_restore = 1'b0;
      frames(LOST_FRAMES - 1, 30);
      chk_eq("clear_hold", 32'({GameState, saw_restore}), 32'({3'd4, 1'b0}));
      frames(1, 30);
      chk_eq("clear_restore", 32'(saw_restore), 32'd1);
      chk_eq("clear_serve", 32'({GameState, SpeedSel}), 32'({3'd1, 1'b0}));
      frames(SERVE_FRAMES, 0);

      cmp_en = 1'b0;
      BrickHit = 1'b1;
      for (int i = 0; i < 9999 - 133; i++) step();
      BrickHit = 1'b0; step();
      cmp_en = 1'b1;
      chk_eq("score_9999", 32'(Score), 32'h9999);
      hit_once();
      chk_eq("score_sat", 32'(Score), 32'h9999);

      BrickHit = 1'b1; reset = 1'b1; step();
      BrickHit = 1'b0; reset = 1'b0;
      chk_eq("rst_mid", 32'({GameState, Score, BallServe}), 32'({3'd0, 16'h0000, 1'b0}));
      step();

      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
